// File: rtl/decode_div_67s_28ns_40_seq.sv
// Iterative restoring divider: signed 67-bit dividend / unsigned 28-bit divisor -> saturated signed 40-bit quotient.
// Define DECODE_DIV_REM_EN to add the signed remainder output rem.
module decode_div_67s_28ns_40_seq #(
    parameter int ID         = 1,
    parameter int DIN0_WIDTH = 67,
    parameter int DIN1_WIDTH = 28,
    parameter int DOUT_WIDTH = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic        [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf,
    output logic                         div_by_zero
`ifdef DECODE_DIV_REM_EN
    ,
    output logic signed [DIN1_WIDTH:0]   rem
`endif
);

    localparam int unused_id = ID;
    localparam int CNT_W = $clog2(DIN0_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIN0_WIDTH);
    localparam logic [DIN0_WIDTH-1:0] NEG_LIM = DIN0_WIDTH'(1) << (DOUT_WIDTH - 1);
    localparam logic [DIN0_WIDTH-1:0] POS_LIM = NEG_LIM - 1'b1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [DIN0_WIDTH-1:0]   quo_p0;
    logic [DIN1_WIDTH-1:0]   rmd_p0;
    logic [DIN1_WIDTH-1:0]   dvs_p0;
    logic                    neg_p0, dz_p0, sat_p1;
    logic [DIN0_WIDTH-1:0]   mag;
    logic [DIN1_WIDTH:0]     rsh;
    logic                    take;

    function automatic logic sat_needed(input logic neg, input logic [DIN0_WIDTH-1:0] m);
        return neg ? (m > NEG_LIM) : (m > POS_LIM);
    endfunction

    function automatic logic signed [DOUT_WIDTH-1:0] sat_apply(input logic neg, input logic sat,
                                                                input logic [DIN0_WIDTH-1:0] m);
        logic [DOUT_WIDTH-1:0] lo;
        lo = m[DOUT_WIDTH-1:0];
        if (sat)
            return neg ? {1'b1, {(DOUT_WIDTH-1){1'b0}}} : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        return neg ? -$signed(lo) : $signed(lo);
    endfunction

    // |din0| as unsigned so the most negative dividend stays exact
    assign mag  = din0[DIN0_WIDTH-1] ? (~din0 + 1'b1) : din0;
    assign rsh  = {rmd_p0, quo_p0[DIN0_WIDTH-1]};
    assign take = rsh >= {1'b0, dvs_p0};

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CALC;
            end
            CALC: if (cnt_q == LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dout        <= '0;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef DECODE_DIV_REM_EN
            rem         <= '0;
`endif
        end else if (ce) begin
            state_q <= state_d;
            if (state_q == IDLE)
                cnt_q <= '0;
            else if (state_q == CALC)
                cnt_q <= cnt_q + 1'b1;
            if (state_q == FIX) begin
                dout        <= sat_apply(neg_p0, sat_p1, quo_p0);
                ovf         <= sat_p1;
                div_by_zero <= dz_p0;
`ifdef DECODE_DIV_REM_EN
                if (dz_p0)
                    rem <= '0;
                else
                    rem <= neg_p0 ? -$signed({1'b0, rmd_p0}) : $signed({1'b0, rmd_p0});
`endif
            end
        end
    end

    // operand capture (p0), iteration, then overflow decision (p1) in the extra CALC cycle
    always_ff @(posedge clk) begin
        if (ce) begin
            case (state_q)
                IDLE: if (in_valid) begin
                    quo_p0 <= mag;
                    rmd_p0 <= '0;
                    dvs_p0 <= din1;
                    neg_p0 <= din0[DIN0_WIDTH-1];
                    dz_p0  <= ~|din1;
                end
                CALC: begin
                    if (cnt_q != LAST) begin
                        rmd_p0 <= DIN1_WIDTH'(take ? rsh - {1'b0, dvs_p0} : rsh);
                        quo_p0 <= {quo_p0[DIN0_WIDTH-2:0], take};
                    end else begin
                        sat_p1 <= dz_p0 | sat_needed(neg_p0, quo_p0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_div_67s_28ns_40_seq.sv
// Scoreboard bench for decode_div_67s_28ns_40_seq; checks rem too when DECODE_DIV_REM_EN is defined.
module tb_decode_div_67s_28ns_40_seq;

    localparam int W0 = 67;
    localparam int W1 = 28;
    localparam int WO = 40;

    logic clk = 1'b0;
    logic reset, ce, in_valid, in_ready, out_valid, out_ready, ovf, div_by_zero;
    logic signed [W0-1:0] din0;
    logic        [W1-1:0] din1;
    logic signed [WO-1:0] dout;
`ifdef DECODE_DIV_REM_EN
    logic signed [W1:0]   rem;
`endif

    always #5 clk = ~clk;

    decode_div_67s_28ns_40_seq #(
        .ID(1), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .ovf(ovf), .div_by_zero(div_by_zero)
`ifdef DECODE_DIV_REM_EN
        , .rem(rem)
`endif
    );

    typedef struct {
        logic signed [WO-1:0] dout;
        logic                 ovf;
        logic                 dz;
        logic signed [W1:0]   rem;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic signed [W0-1:0] a, input logic [W1-1:0] b);
        exp_t e;
        logic signed [W0+1:0] sa, sb, q, r;
        logic signed [W0+1:0] qmax, qmin;
        qmax = (70'sd1 <<< (WO - 1)) - 1;
        qmin = -(70'sd1 <<< (WO - 1));
        sa = a;
        sb = {{(W0+2-W1){1'b0}}, b};
        e.dz = (b == 0);
        if (b == 0) begin
            e.ovf  = 1'b1;
            e.dout = (a < 0) ? qmin[WO-1:0] : qmax[WO-1:0];
            e.rem  = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.rem = r[W1:0];
            if (q > qmax) begin
                e.ovf = 1'b1; e.dout = qmax[WO-1:0];
            end else if (q < qmin) begin
                e.ovf = 1'b1; e.dout = qmin[WO-1:0];
            end else begin
                e.ovf = 1'b0; e.dout = q[WO-1:0];
            end
        end
        return e;
    endfunction

    task automatic start_op(input logic signed [W0-1:0] a, input logic [W1-1:0] b,
                            input bit push);
        bit ok;
        if (push) sb_q.push_back(model(a, b));
        din0 = a;
        din1 = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (in_ready && ce) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("accept", 128'(ok), 128'(1));
    endtask

    task automatic wait_out(input int exp_lat, input int gap_at, input int gap_len);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            ce = !(gap_len > 0 && cyc >= gap_at && cyc < gap_at + gap_len);
        end
        ce = 1'b1;
        check_val("latency", 128'(cyc), 128'(exp_lat));
    endtask

    task automatic check_result();
        exp_t e;
        check_val("out_valid", 128'(out_valid), 128'(1));
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 128'(1), 128'(0));
            return;
        end
        e = sb_q.pop_front();
        check_val("dout", 128'(dout), 128'(e.dout));
        check_val("ovf", 128'(ovf), 128'(e.ovf));
        check_val("div_by_zero", 128'(div_by_zero), 128'(e.dz));
`ifdef DECODE_DIV_REM_EN
        check_val("rem", 128'(rem), 128'(e.rem));
`endif
    endtask

    task automatic run(input logic signed [W0-1:0] a, input logic [W1-1:0] b);
        start_op(a, b, 1'b1);
        wait_out(69, 0, 0);
        check_result();
        @(posedge clk); #1;
        check_val("valid_drop", 128'(out_valid), 128'(0));
        check_val("ready_back", 128'(in_ready), 128'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [W0-1:0] a;
        logic [W1-1:0] b;
        int hits;
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        din0 = '0; din1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check_val("rst_in_ready", 128'(in_ready), 128'(1));
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_dout", 128'(dout), 128'(0));
        check_val("rst_ovf", 128'(ovf), 128'(0));
        check_val("rst_dz", 128'(div_by_zero), 128'(0));

        run(67'sd1000, 28'd7);
        run(-67'sd1000, 28'd7);
        run(-67'sd7, 28'd2);
        run(67'sd1 <<< 50, 28'd1);
        run(-(67'sd1 <<< 39), 28'd1);
        run(-(67'sd1 <<< 39) - 1, 28'd1);
        run(67'sd1 <<< 39, 28'd2);
        a = {1'b1, 66'b0};
        run(a, 28'd1);
        run(67'sd5, 28'd0);
        run(-67'sd5, 28'd0);
        run(67'sd0, 28'd0);
        run(-67'sd1, 28'hFFF_FFFF);

        // result held under back-pressure, next operands wait for the handshake
        out_ready = 1'b0;
        start_op(67'sd1000, 28'd7, 1'b1);
        wait_out(69, 0, 0);
        check_result();
        din0 = -67'sd1000; din1 = 28'd7; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", 128'(out_valid), 128'(1));
            check_val("hold_dout", 128'(dout), 128'(142));
            check_val("hold_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        start_op(-67'sd1000, 28'd7, 1'b1);
        wait_out(69, 0, 0);
        check_result();
        @(posedge clk); #1;

        // clock enable stall mid-CALC
        start_op(67'sd123456789, 28'd1234, 1'b1);
        wait_out(79, 20, 10);
        check_result();
        @(posedge clk); #1;
        check_val("ce_valid_drop", 128'(out_valid), 128'(0));

        // reset abandons an operation in flight
        start_op(-67'sd999999, 28'd77, 1'b0);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("abort_ready", 128'(in_ready), 128'(1));
        check_val("abort_valid", 128'(out_valid), 128'(0));
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        check_val("abort_no_output", 128'(hits), 128'(0));

        for (int i = 0; i < 6; i++) begin
            a = W0'({$urandom(), $urandom(), $urandom()});
            a = a >>> $urandom_range(0, 60);
            b = (i % 2 == 1) ? W1'($urandom_range(1, 255)) : W1'($urandom());
            if (b == 0) b = 28'd3;
            run(a, b);
        end

        check_val("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
